// File: rtl/permutation_inv_pkg.sv
// Shared types, constants and helpers for the inverse Ascon permutation.
package permutation_inv_pkg;

  localparam int NUM_WORDS = 5;
  localparam int WORD_W    = 64;

  // Word 0 is x0 (S-box column MSB), word 4 is x4.
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } fsm_state_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  // Forward Ascon S-box, column value with x0 as MSB.
  localparam logic [4:0] sbox [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // Exact inverse of sbox.
  localparam logic [4:0] sbox_inv [32] = '{
    5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
    5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
    5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
    5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
  };

  // Forward linear-layer rotation pairs per word.
  localparam int unsigned ROT_A [NUM_WORDS] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [NUM_WORDS] = '{28, 39, 6, 17, 41};

  // Round constant for round index r; indices above 11 carry no constant.
  function automatic logic [7:0] round_constant(input logic [3:0] r);
    case (r)
      4'd0:    return 8'hf0;
      4'd1:    return 8'he1;
      4'd2:    return 8'hd2;
      4'd3:    return 8'hc3;
      4'd4:    return 8'hb4;
      4'd5:    return 8'ha5;
      4'd6:    return 8'h96;
      4'd7:    return 8'h87;
      4'd8:    return 8'h78;
      4'd9:    return 8'h69;
      4'd10:   return 8'h5a;
      4'd11:   return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> (n % 64)) | (x << ((64 - (n % 64)) % 64));
  endfunction

  // L^-1 = L^63 = prod_{k=0..5} L^(2^k); each factor is I + R^(a*2^k) + R^(b*2^k).
  function automatic logic [63:0] inv_pl_word(input logic [63:0] x,
                                              input int unsigned a,
                                              input int unsigned b);
    logic [63:0] y;
    y = x;
    for (int k = 0; k < 6; k++) begin
      y = y ^ ror64(y, (a << k) % 64) ^ ror64(y, (b << k) % 64);
    end
    return y;
  endfunction

endpackage

// File: rtl/permutation_inv_round_inv.sv
// One inverse Ascon round: inverse pL, inverse pS, then pC (self-inverse).
module sbox_inv_col
  import permutation_inv_pkg::*;
(
  input  logic [4:0] col_in,
  output logic [4:0] col_out
);
  assign col_out = sbox_inv[col_in];
endmodule

module constant_addition
  import permutation_inv_pkg::*;
(
  input  type_state  state_in,
  input  logic [3:0] round,
  output type_state  state_out
);
  // XOR the round constant into the low byte of word 2.
  always_comb begin
    state_out          = state_in;
    state_out[2][7:0]  = state_in[2][7:0] ^ round_constant(round);
  end
endmodule

module round_inv
  import permutation_inv_pkg::*;
(
  input  type_state  state_in,
  input  logic [3:0] round,
  output type_state  state_out
);
  type_state               lin;
  type_state               sub;
  logic [WORD_W-1:0][4:0]  col_in;
  logic [WORD_W-1:0][4:0]  col_out;

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_lin
    assign lin[w] = inv_pl_word(state_in[w], ROT_A[w], ROT_B[w]);
  end

  for (genvar j = 0; j < WORD_W; j++) begin : g_col
    assign col_in[j] = {lin[0][j], lin[1][j], lin[2][j], lin[3][j], lin[4][j]};
    sbox_inv_col u_col (.col_in(col_in[j]), .col_out(col_out[j]));
    assign sub[0][j] = col_out[j][4];
    assign sub[1][j] = col_out[j][3];
    assign sub[2][j] = col_out[j][2];
    assign sub[3][j] = col_out[j][1];
    assign sub[4][j] = col_out[j][0];
  end

  constant_addition u_pc (.state_in(sub), .round(round), .state_out(state_out));
endmodule

// File: rtl/permutation_inv.sv
// Iterative inverse Ascon permutation: undoes rounds 11 down to first_round_i,
// one round per clock, with a start/busy/done handshake.
module permutation_inv
  import permutation_inv_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] first_round_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o
);
  fsm_state_t fsm_q;
  type_state  state_q;
  type_state  round_out;
  logic [3:0] round_q;
  logic [3:0] first_q;

  round_inv u_round (.state_in(state_q), .round(round_q), .state_out(round_out));

  // Control FSM and state register; done_o is registered out of DONE so it
  // lands in the IDLE cycle that follows.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      round_q <= LAST_ROUND;
      first_q <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            first_q <= first_round_i;
            round_q <= LAST_ROUND;
            busy_o  <= 1'b1;
            fsm_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (first_q > LAST_ROUND) begin
            busy_o <= 1'b0;
            fsm_q  <= ST_DONE;
          end else begin
            fsm_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_q <= round_out;
          if (round_q == first_q) begin
            busy_o <= 1'b0;
            fsm_q  <= ST_DONE;
          end else begin
            round_q <= round_q - 4'd1;
          end
        end
        ST_DONE: begin
          done_o <= 1'b1;
          fsm_q  <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_permutation_inv.sv
// Directed bench for permutation_inv: round trips against a forward model,
// zero-round path, handshake timing and reset abort.
module tb_permutation_inv;
  import permutation_inv_pkg::*;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [3:0] first_round_i;
  type_state  state_i;
  type_state  state_o;
  logic       busy_o;
  logic       done_o;

  int n_vec = 0;
  int n_err = 0;

  localparam int unsigned MA [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned MB [5] = '{28, 39, 6, 17, 41};

  always #5 clock_i = ~clock_i;

  permutation_inv dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .first_round_i(first_round_i), .state_i(state_i), .state_o(state_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [63:0] ror_m(input logic [63:0] x, input int unsigned n);
    if (n == 0) return x;
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] fwd_pl(input logic [63:0] x, input int w);
    return x ^ ror_m(x, MA[w]) ^ ror_m(x, MB[w]);
  endfunction

  // Bit-sliced forward Ascon S-box layer.
  function automatic type_state ps_layer(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0; o[1] = x1; o[2] = x2; o[3] = x3; o[4] = x4;
    return o;
  endfunction

  function automatic logic [4:0] sbox_m(input logic [4:0] x);
    type_state s;
    s = '0;
    for (int w = 0; w < 5; w++) s[w][0] = x[4-w];
    s = ps_layer(s);
    return {s[0][0], s[1][0], s[2][0], s[3][0], s[4][0]};
  endfunction

  function automatic type_state fwd_perm(input type_state s_in, input int first);
    type_state s;
    s = s_in;
    for (int r = first; r < 12; r++) begin
      s[2][7:0] = s[2][7:0] ^ 8'(((15 - r) << 4) | r);
      s = ps_layer(s);
      for (int w = 0; w < 5; w++) s[w] = fwd_pl(s[w], w);
    end
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation; start is accepted at edge E0. Reports the state at
  // done_o, the edge index after which done_o was seen, busy cycles and
  // done pulses over a short tail after completion.
  task automatic run_op(input type_state st, input logic [3:0] fr, input bit hold,
                        output type_state res, output int done_edge,
                        output int busy_cycles, output int done_cnt);
    @(negedge clock_i);
    start_i = 1'b1; state_i = st; first_round_i = fr;
    @(posedge clock_i);
    @(negedge clock_i);
    if (!hold) start_i = 1'b0;
    first_round_i = ~fr;
    state_i       = ~st;
    busy_cycles = busy_o ? 1 : 0;
    done_cnt    = done_o ? 1 : 0;
    done_edge   = -1;
    res         = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock_i);
      @(negedge clock_i);
      if (busy_o) busy_cycles++;
      if (done_o) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = k;
          res       = state_o;
          start_i   = 1'b0;
        end
      end
      if (done_edge >= 0 && k >= done_edge + 4) break;
    end
    start_i = 1'b0;
  endtask

  type_state orig, fwd, res;
  int        de, bc, dc;
  logic [63:0] v;

  initial begin
    reset_i = 1'b1; start_i = 1'b0; first_round_i = '0; state_i = '0;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    chk("reset_state", 320'(state_o), 320'(0));
    chk("reset_busy",  320'(busy_o),  320'(0));
    chk("reset_done",  320'(done_o),  320'(0));

    for (int x = 0; x < 32; x++)
      chk("sbox_inv_of_sbox", 320'(sbox_inv[sbox_m(5'(x))]), 320'(x));

    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 4; i++) begin
        v = (i == 0) ? 64'h1 : (i == 1) ? 64'h8000000000000000 : {$urandom, $urandom};
        chk("inv_pl", 320'(inv_pl_word(fwd_pl(v, w), ROT_A[w], ROT_B[w])), 320'(v));
      end
    end

    // p12 round trip on the Ascon-128 IV state
    orig = '0; orig[0] = 64'h80400c0600000000;
    fwd  = fwd_perm(orig, 0);
    run_op(fwd, 4'd0, 1'b0, res, de, bc, dc);
    chk("p12_state", 320'(res), 320'(orig));
    chk("p12_done_edge", 320'(de), 320'(14));
    chk("p12_busy", 320'(bc), 320'(13));
    chk("p12_done_cnt", 320'(dc), 320'(1));

    // p6 round trips on random states
    for (int t = 0; t < 3; t++) begin
      orig = rand_state();
      run_op(fwd_perm(orig, 6), 4'd6, 1'b0, res, de, bc, dc);
      chk("p6_state", 320'(res), 320'(orig));
      chk("p6_done_edge", 320'(de), 320'(8));
      chk("p6_busy", 320'(bc), 320'(7));
    end

    // p8 round trip
    orig = rand_state();
    run_op(fwd_perm(orig, 4), 4'd4, 1'b0, res, de, bc, dc);
    chk("p8_state", 320'(res), 320'(orig));
    chk("p8_done_edge", 320'(de), 320'(10));

    // zero rounds
    orig = rand_state();
    run_op(orig, 4'd13, 1'b0, res, de, bc, dc);
    chk("zero13_state", 320'(res), 320'(orig));
    chk("zero13_done_edge", 320'(de), 320'(2));
    chk("zero13_busy", 320'(bc), 320'(1));
    orig = rand_state();
    run_op(orig, 4'd12, 1'b0, res, de, bc, dc);
    chk("zero12_state", 320'(res), 320'(orig));
    chk("zero12_done_edge", 320'(de), 320'(2));

    // start held high for the whole run
    orig = rand_state();
    run_op(fwd_perm(orig, 6), 4'd6, 1'b1, res, de, bc, dc);
    chk("hold_state", 320'(res), 320'(orig));
    chk("hold_done_cnt", 320'(dc), 320'(1));
    chk("hold_busy", 320'(bc), 320'(7));
    chk("hold_idle_busy", 320'(busy_o), 320'(0));

    // reset at edge E4 aborts the run
    orig = '0; orig[0] = 64'h80400c0600000000;
    fwd  = fwd_perm(orig, 0);
    @(negedge clock_i);
    start_i = 1'b1; state_i = fwd; first_round_i = 4'd0;
    @(posedge clock_i);
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    chk("pre_reset_busy", 320'(busy_o), 320'(1));
    reset_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    chk("abort_busy", 320'(busy_o), 320'(0));
    chk("abort_state", 320'(state_o), 320'(0));
    chk("abort_done", 320'(done_o), 320'(0));
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock_i);
      if (done_o) dc++;
    end
    chk("abort_no_done", 320'(dc), 320'(0));

    // restart after reset
    run_op(fwd, 4'd0, 1'b0, res, de, bc, dc);
    chk("restart_state", 320'(res), 320'(orig));
    chk("restart_done_edge", 320'(de), 320'(14));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/permutation_inv.md
# permutation_inv

Iterative inverse of the Ascon permutation. The block takes a 320-bit state, runs the inverse round function from round index 11 down to a programmable first round, one round per clock, and signals completion with a start/busy/done handshake. It sits beside the forward permutation in the datapath. Its uses are decryption-side experiments, round-trip self-checks, and verification of the forward permutation.

## Interface
Parameters:
- none. Round count is set at run time by `first_round_i`.

Ports:
- `clock_i`  in  1  — single clock; all state updates on the rising edge.
- `reset_i`  in  1  — synchronous, active-high reset.
- `start_i`  in  1  — request; sampled only in IDLE.
- `first_round_i`  in  4  — lowest round index to undo:
  - 0 → p12, 4 → p8, 6 → p6;
  - 12–15 → zero rounds.
- `state_i`  in  `type_state` (5×64)  — state to invert; sampled with `start_i`.
- `state_o`  out  `type_state`  — state register contents.
- `busy_o`  out  1  — high in LOAD and RUN.
- `done_o`  out  1  — one-cycle pulse; `state_o` holds the result.

## Operation
- Inverse round r is applied in this order: inverse pL, then inverse pS, then pC.
  - pC XORs `round_constant[r]` into word 2 bits 7:0. It is its own inverse.
- Inverse pL, per word w with forward rotation pair (a,b):
  - Pairs: w0 (19,28), w1 (61,39), w2 (1,6), w3 (10,17), w4 (7,41).
  - Basis: L^64 = identity, so L^-1 = L^63.
  - Implementation: six cascaded stages k=0..5, each x ← x ^ ror(x, a·2^k mod 64) ^ ror(x, b·2^k mod 64).
  - Purely combinational.
- Inverse pS is applied column-wise for j=0..63.
  - Input column is 5 bits {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as the MSB.
  - The column is looked up in `sbox_inv`, the exact inverse of the forward 32-entry Ascon S-box.
- States:
  - IDLE:
    - On `start_i`, load `state_i` into the state register.
    - Set `round_q` = 11 and go to LOAD.
  - LOAD:
    - If `first_round_i` > 11, go to DONE with the state unchanged.
    - Otherwise go to RUN.
  - RUN:
    - Each cycle: state ← invround(state, `round_q`).
    - If `round_q` == `first_round_i`, go to DONE.
    - Otherwise `round_q` ← `round_q` − 1.
  - DONE:
    - `done_o` is high for exactly one cycle.
    - Go to IDLE.
- `first_round_i` is captured at start into a register. Later changes to the input have no effect on a running operation.
- `start_i` is ignored outside IDLE. There is no queuing.
- `state_o` holds its value in IDLE until the next accepted start.

## Timing
- Reset values: FSM = IDLE, state register = 0, `round_q` = 11, `busy_o` = 0, `done_o` = 0.
- Reset mid-operation aborts the run. The reset values apply on the next edge and no `done_o` is produced.
- Latency with N = 12 − `first_round_i` rounds:
  - Start accepted at edge E0.
  - RUN updates at edges E2..E(N+1).
  - `done_o` is high in the cycle after edge E(N+2).
  - Throughput is one operation per N+3 cycles.
- Zero-round case (`first_round_i` ≥ 12): `done_o` is high in the cycle after edge E2, and `state_o` equals the loaded `state_i`.
- `start_i` is sampled in the DONE cycle but ignored. It is accepted in the following IDLE cycle.

## Structure
- Add to `ascon_pack`:
  - `sbox_inv[0:31]` constant.
  - Rotation-pair constants per word.
  - FSM state enum.
  - `round_constant` is reused unchanged from the package.
- Sub-module `round_inv`: combinational, ports state in, round index in, state out.
  - Internally it chains the inverse pL and inverse pS functions.
  - It instantiates the existing constant-addition module for pC.

## Test plan
- S-box sanity: for all x in 0..31, `sbox_inv[sbox[x]]` == x.
- Inverse pL sanity: for word values 0x1, 0x8000000000000000 and random values, on all five words, inverse pL applied to pL(x) == x.
- Round trip p12:
  - Stimulus: forward p12 of state {0x80400c0600000000, 0, 0, 0, 0} from the golden model, then start with `first_round_i` = 0.
  - Required response: the original state at `done_o`, with `done_o` in the cycle after edge E14.
- Round trip p6:
  - Stimulus: forward p6 (rounds 6..11) of random states.
  - Required response: original state recovered, `done_o` after edge E8, and `busy_o` high for exactly 7 cycles.
- Zero rounds: `first_round_i` = 13 → `state_o` == `state_i`, with `done_o` after edge E2.
- Protocol:
  - `start_i` held high during a run → a single operation only.
  - `reset_i` asserted at edge E4 → next cycle `busy_o` = 0 and `state_o` = 0, with no `done_o` pulse.
  - Restart after reset completes normally.
